// File: rtl/assoc_cache_ctrl.sv
// Set-associative, write-through / no-write-allocate cache controller with
// round-robin replacement, single outstanding backing-memory transaction.
module assoc_cache_ctrl #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned INDEX_W = 5,
    parameter int unsigned WAYS    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] wdata,
    input  logic              flush,
    output logic [DATA_W-1:0] rdata,
    output logic              freeze,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
);

    localparam int unsigned SETS  = 1 << INDEX_W;
    localparam int unsigned TAG_W = ADDR_W - INDEX_W;
    localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_t;

    state_t             state_q;
    logic [SETS-1:0]    valid_q [WAYS];
    logic [TAG_W-1:0]   tag_q   [WAYS][SETS];
    logic [DATA_W-1:0]  data_q  [WAYS][SETS];
    logic [WAY_W-1:0]   rr_q    [SETS];

    logic [INDEX_W-1:0] set_idx;
    logic [TAG_W-1:0]   addr_tag;
    logic               hit;
    logic [WAY_W-1:0]   hit_way;
    logic [DATA_W-1:0]  hit_data;
    logic               victim_free;
    logic [WAY_W-1:0]   victim;
    logic [WAY_W-1:0]   rr_next;
    logic               req_rd;
    logic               idle_ok;

    assign set_idx  = address[INDEX_W-1:0];
    assign addr_tag = address[ADDR_W-1:INDEX_W];

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Tag compare across ways; at most one way can match.
    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        hit_data = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w][set_idx] && (tag_q[w][set_idx] == addr_tag)) begin
                hit      = 1'b1;
                hit_way  = WAY_W'(w);
                hit_data = data_q[w][set_idx];
            end
        end
    end

    // Victim: lowest invalid way, else the set's round-robin pointer.
    always_comb begin
        victim_free = 1'b0;
        victim      = rr_q[set_idx];
        for (int w = 0; w < WAYS; w++) begin
            if (!victim_free && !valid_q[w][set_idx]) begin
                victim_free = 1'b1;
                victim      = WAY_W'(w);
            end
        end
        rr_next = (rr_q[set_idx] == WAY_W'(WAYS - 1)) ? '0 : WAY_W'(rr_q[set_idx] + 1'b1);
    end

    // Request-side outputs are combinational so hits complete with zero latency.
    always_comb begin
        idle_ok   = !rst && (state_q == IDLE) && !flush;
        req_rd    = idle_ok && rd_en && !wr_en;
        freeze    = 1'b0;
        rdata     = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    freeze = flush || wr_en || (rd_en && !hit);
                    if (req_rd && hit) rdata = hit_data;
                end
                RD_MISS: begin
                    freeze   = !mem_ack;
                    mem_req  = 1'b1;
                    mem_addr = address;
                    if (mem_ack) rdata = mem_rdata;
                end
                WR_THRU: begin
                    freeze    = !mem_ack;
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = address;
                    mem_wdata = wdata;
                end
                default: freeze = 1'b0;
            endcase
        end
    end

    // State, line arrays and statistics; replacement is round-robin, so recency needs no storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            hit_cnt  <= '0;
            miss_cnt <= '0;
            for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
            for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (flush) begin
                        for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
                        for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
                    end else if (wr_en) begin
                        if (hit) begin
                            data_q[hit_way][set_idx] <= wdata;
                            hit_cnt <= sat_inc(hit_cnt);
                        end else begin
                            miss_cnt <= sat_inc(miss_cnt);
                        end
                        state_q <= WR_THRU;
                    end else if (rd_en) begin
                        if (hit) begin
                            hit_cnt <= sat_inc(hit_cnt);
                        end else begin
                            miss_cnt <= sat_inc(miss_cnt);
                            state_q  <= RD_MISS;
                        end
                    end
                end
                RD_MISS: begin
                    if (mem_ack) begin
                        data_q[victim][set_idx]  <= mem_rdata;
                        tag_q[victim][set_idx]   <= addr_tag;
                        valid_q[victim][set_idx] <= 1'b1;
                        if (!victim_free) rr_q[set_idx] <= rr_next;
                        state_q <= IDLE;
                    end
                end
                WR_THRU: begin
                    if (mem_ack) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// Directed bench for assoc_cache_ctrl (2 ways, 8 sets, 16-bit addresses).
module tb_assoc_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [15:0] address = '0;
    logic [15:0] wdata = '0;
    logic        flush = 1'b0;
    logic [15:0] rdata;
    logic        freeze;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    int checks = 0;
    int errs   = 0;

    assoc_cache_ctrl #(
        .ADDR_W(16), .DATA_W(16), .INDEX_W(3), .WAYS(2)
    ) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
        .address(address), .wdata(wdata), .flush(flush),
        .rdata(rdata), .freeze(freeze),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    // Inputs change 2 ns after the rising edge; outputs are sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; flush = 1'b0; mem_ack = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Read that is known to miss, acknowledged on the first RD_MISS cycle.
    task automatic fill(input logic [15:0] a, input logic [15:0] d);
        rd_en = 1'b1; address = a;
        step();
        mem_ack = 1'b1; mem_rdata = d;
        step();
        mem_ack = 1'b0; rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rd_en = 1'b1; address = 16'h0105;
        step();
        #1;
        checks++; if (freeze !== 1'b0 || mem_req !== 1'b0 || rdata !== 16'h0) begin
            errs++; $display("FAIL reset_outputs: freeze=%b mem_req=%b rdata=%h expected 0/0/0000", freeze, mem_req, rdata);
        end
        rd_en = 1'b0;
        step();
        rst = 1'b0;
        #1;
        checks++; if (hit_cnt !== 16'h0 || miss_cnt !== 16'h0) begin
            errs++; $display("FAIL reset_counters: hit=%h miss=%h expected 0000/0000", hit_cnt, miss_cnt);
        end
        checks++; if (freeze !== 1'b0 || mem_req !== 1'b0 || rdata !== 16'h0) begin
            errs++; $display("FAIL idle_outputs: freeze=%b mem_req=%b rdata=%h expected 0/0/0000", freeze, mem_req, rdata);
        end
    endtask

    task automatic test_idle_ack();
        do_reset();
        mem_ack = 1'b1; mem_rdata = 16'hFFFF;
        #1;
        checks++; if (rdata !== 16'h0 || freeze !== 1'b0) begin
            errs++; $display("FAIL idle_ack: rdata=%h freeze=%b expected 0000/0", rdata, freeze);
        end
        step();
        mem_ack = 1'b0; rd_en = 1'b1; address = 16'h0105;
        #1;
        checks++; if (freeze !== 1'b1) begin
            errs++; $display("FAIL idle_ack_nofill: freeze=%b expected 1", freeze);
        end
        rd_en = 1'b0;
    endtask

    task automatic test_cold_read();
        int fz;
        fz = 0;
        do_reset();
        rd_en = 1'b1; address = 16'h0105;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (freeze === 1'b1) fz++;
            if (c == 1) begin
                checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0105) begin
                    errs++; $display("FAIL cold_memreq: req=%b we=%b addr=%h expected 1/0/0105", mem_req, mem_we, mem_addr);
                end
            end
            step();
        end
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        #1;
        checks++; if (fz != 4) begin
            errs++; $display("FAIL cold_freeze_cycles: got %0d expected 4", fz);
        end
        checks++; if (freeze !== 1'b0 || rdata !== 16'hBEEF) begin
            errs++; $display("FAIL cold_ack: freeze=%b rdata=%h expected 0/beef", freeze, rdata);
        end
        step();
        mem_ack = 1'b0; rd_en = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || rdata !== 16'h0) begin
            errs++; $display("FAIL cold_after_ack: mem_req=%b rdata=%h expected 0/0000", mem_req, rdata);
        end
        rd_en = 1'b1;
        #1;
        checks++; if (freeze !== 1'b0 || rdata !== 16'hBEEF) begin
            errs++; $display("FAIL cold_reread: freeze=%b rdata=%h expected 0/beef", freeze, rdata);
        end
        step();
        rd_en = 1'b0;
        #1;
        checks++; if (hit_cnt !== 16'd1 || miss_cnt !== 16'd1) begin
            errs++; $display("FAIL cold_counts: hit=%0d miss=%0d expected 1/1", hit_cnt, miss_cnt);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        fill(16'h0105, 16'h1111);
        fill(16'h0205, 16'h2222);
        fill(16'h0305, 16'h3333);
        rd_en = 1'b1; address = 16'h0205;
        #1;
        checks++; if (freeze !== 1'b0 || rdata !== 16'h2222) begin
            errs++; $display("FAIL rr_0205_hit: freeze=%b rdata=%h expected 0/2222", freeze, rdata);
        end
        step();
        address = 16'h0305;
        #1;
        checks++; if (freeze !== 1'b0 || rdata !== 16'h3333) begin
            errs++; $display("FAIL rr_0305_hit: freeze=%b rdata=%h expected 0/3333", freeze, rdata);
        end
        step();
        address = 16'h0105;
        #1;
        checks++; if (freeze !== 1'b1 || rdata !== 16'h0) begin
            errs++; $display("FAIL rr_0105_evicted: freeze=%b rdata=%h expected 1/0000", freeze, rdata);
        end
        step();
        mem_ack = 1'b1; mem_rdata = 16'h1111;
        step();
        mem_ack = 1'b0; rd_en = 1'b0;
        #1;
        checks++; if (hit_cnt !== 16'd2 || miss_cnt !== 16'd4) begin
            errs++; $display("FAIL rr_counts: hit=%0d miss=%0d expected 2/4", hit_cnt, miss_cnt);
        end
    endtask

    task automatic test_write();
        do_reset();
        fill(16'h0205, 16'h2222);
        wr_en = 1'b1; address = 16'h0205; wdata = 16'h1234;
        #1;
        checks++; if (freeze !== 1'b1 || mem_req !== 1'b0) begin
            errs++; $display("FAIL wr_idle: freeze=%b mem_req=%b expected 1/0", freeze, mem_req);
        end
        step();
        #1;
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h0205 || mem_wdata !== 16'h1234) begin
            errs++; $display("FAIL wr_thru: req=%b we=%b addr=%h wdata=%h expected 1/1/0205/1234", mem_req, mem_we, mem_addr, mem_wdata);
        end
        mem_ack = 1'b1;
        #1;
        checks++; if (freeze !== 1'b0) begin
            errs++; $display("FAIL wr_ack_freeze: got %b expected 0", freeze);
        end
        step();
        mem_ack = 1'b0; wr_en = 1'b0; rd_en = 1'b1;
        #1;
        checks++; if (freeze !== 1'b0 || rdata !== 16'h1234) begin
            errs++; $display("FAIL wr_reread: freeze=%b rdata=%h expected 0/1234", freeze, rdata);
        end
        step();
        rd_en = 1'b0; wr_en = 1'b1; address = 16'h0405; wdata = 16'h5555;
        step();
        mem_ack = 1'b1;
        #1;
        checks++; if (mem_we !== 1'b1 || mem_addr !== 16'h0405 || mem_wdata !== 16'h5555) begin
            errs++; $display("FAIL wr_miss_mem: we=%b addr=%h wdata=%h expected 1/0405/5555", mem_we, mem_addr, mem_wdata);
        end
        step();
        mem_ack = 1'b0; wr_en = 1'b0; rd_en = 1'b1;
        #1;
        checks++; if (freeze !== 1'b1) begin
            errs++; $display("FAIL wr_no_allocate: freeze=%b expected 1", freeze);
        end
        step();
        mem_ack = 1'b1; mem_rdata = 16'h0999;
        step();
        mem_ack = 1'b0;
        wr_en = 1'b1; address = 16'h0205; wdata = 16'h7777;
        #1;
        checks++; if (freeze !== 1'b1) begin
            errs++; $display("FAIL rdwr_as_write: freeze=%b expected 1", freeze);
        end
        step();
        #1;
        checks++; if (mem_we !== 1'b1 || mem_wdata !== 16'h7777) begin
            errs++; $display("FAIL rdwr_mem: we=%b wdata=%h expected 1/7777", mem_we, mem_wdata);
        end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        #1;
        checks++; if (hit_cnt !== 16'd3 || miss_cnt !== 16'd3) begin
            errs++; $display("FAIL wr_counts: hit=%0d miss=%0d expected 3/3", hit_cnt, miss_cnt);
        end
    endtask

    task automatic test_flush();
        do_reset();
        fill(16'h0105, 16'h1111);
        flush = 1'b1; rd_en = 1'b1; address = 16'h0105;
        #1;
        checks++; if (freeze !== 1'b1 || rdata !== 16'h0) begin
            errs++; $display("FAIL flush_idle: freeze=%b rdata=%h expected 1/0000", freeze, rdata);
        end
        step();
        flush = 1'b0;
        #1;
        checks++; if (freeze !== 1'b1) begin
            errs++; $display("FAIL flush_cleared: freeze=%b expected 1", freeze);
        end
        step();
        flush = 1'b1;
        step();
        mem_ack = 1'b1; mem_rdata = 16'hAAAA;
        #1;
        checks++; if (freeze !== 1'b0 || rdata !== 16'hAAAA) begin
            errs++; $display("FAIL flush_in_miss_ack: freeze=%b rdata=%h expected 0/aaaa", freeze, rdata);
        end
        step();
        mem_ack = 1'b0; flush = 1'b0;
        #1;
        checks++; if (freeze !== 1'b0 || rdata !== 16'hAAAA) begin
            errs++; $display("FAIL flush_in_miss_fill: freeze=%b rdata=%h expected 0/aaaa", freeze, rdata);
        end
        step();
        rd_en = 1'b0;
        #1;
        checks++; if (hit_cnt !== 16'd1 || miss_cnt !== 16'd2) begin
            errs++; $display("FAIL flush_counts: hit=%0d miss=%0d expected 1/2", hit_cnt, miss_cnt);
        end
    endtask

    task automatic test_reset_mid_miss();
        do_reset();
        rd_en = 1'b1; address = 16'h0105;
        step();
        rst = 1'b1; rd_en = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || freeze !== 1'b0) begin
            errs++; $display("FAIL rst_mid_outputs: mem_req=%b freeze=%b expected 0/0", mem_req, freeze);
        end
        step();
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        #1;
        checks++; if (mem_req !== 1'b0 || freeze !== 1'b0 || rdata !== 16'h0) begin
            errs++; $display("FAIL rst_mid_late_ack: mem_req=%b freeze=%b rdata=%h expected 0/0/0000", mem_req, freeze, rdata);
        end
        step();
        mem_ack = 1'b0;
        #1;
        checks++; if (hit_cnt !== 16'h0 || miss_cnt !== 16'h0) begin
            errs++; $display("FAIL rst_mid_counts: hit=%h miss=%h expected 0000/0000", hit_cnt, miss_cnt);
        end
        rd_en = 1'b1;
        #1;
        checks++; if (freeze !== 1'b1) begin
            errs++; $display("FAIL rst_mid_no_line: freeze=%b expected 1", freeze);
        end
        rd_en = 1'b0;
    endtask

    task automatic test_saturation();
        do_reset();
        fill(16'h0105, 16'h1111);
        rd_en = 1'b1; address = 16'h0105;
        for (int i = 0; i < 65534; i++) step();
        #1;
        checks++; if (hit_cnt !== 16'hFFFE) begin
            errs++; $display("FAIL sat_before: hit=%h expected fffe", hit_cnt);
        end
        for (int i = 0; i < 6; i++) step();
        #1;
        checks++; if (hit_cnt !== 16'hFFFF || freeze !== 1'b0 || miss_cnt !== 16'd1) begin
            errs++; $display("FAIL sat_hold: hit=%h freeze=%b miss=%0d expected ffff/0/1", hit_cnt, freeze, miss_cnt);
        end
        rd_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle_ack();
        test_cold_read();
        test_round_robin();
        test_write();
        test_flush();
        test_reset_mid_miss();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
        $finish;
    end

endmodule
